niu_sii_req_packetizer: RTL and testbench
=========================================

// Module: niu_sii_req_packetizer
// PURPOSE
//  NIU-side DMA request issue stage; drives the NIU->SII inbound request bus.
//  Accepts DMA read/write requests from NIU DMA engines and emits SII header and payload cycles.
//  Write payload is fully buffered before its header issues, so the 4 payload beats are back-to-back.
//  Tracks ordered/bypass queue credits returned by SII dequeue pulses.
// PARAMETERS
//  OQ_CREDITS  16  SII ordered-queue entries; initial ordered credit count, 1..31
//  BQ_CREDITS  4   SII bypass-queue entries; initial bypass credit count, 1..31
// PORTS
//  iol2clk            in   1    clock; all logic on rising edge
//  rst_l              in   1    asynchronous reset, active-low
//  req_vld            in   1    DMA request header valid
//  req_rdy            out  1    request accepted on req_vld & req_rdy
//  req_write          in   1    1 = write (64B, 4 beats), 0 = read
//  req_bypass         in   1    1 = bypass queue, 0 = ordered queue
//  req_hdr            in   128  header bits
//  req_be             in   16   write byte enables, applied to all 4 payload beats
//  pld_vld            in   1    write payload beat valid
//  pld_rdy            out  1    payload beat accepted on pld_vld & pld_rdy
//  pld_data           in   128  write payload beat
//  niu_sii_hdr_vld    out  1    header cycle
//  niu_sii_reqbypass  out  1    header targets bypass queue; valid with hdr_vld
//  niu_sii_datareq    out  1    header is a write; valid with hdr_vld
//  niu_sii_datareq16  out  1    tied 0 (16-byte writes unsupported)
//  niu_sii_data       out  128  header bits on header cycle, payload on payload cycles
//  niu_sii_parity     out  8    parity[i] = ~^data[16i+15:16i] (odd, per 16-bit lane)
//  niu_sii_be         out  16   req_be on payload cycles, 0 otherwise
//  sii_niu_oqdq       in   1    ordered-queue entry freed; +1 ordered credit
//  sii_niu_bqdq       in   1    bypass-queue entry freed; +1 bypass credit
//  credit_err         out  1    sticky: credit return beyond initial count
// BEHAVIOUR
//  Reset: state IDLE; req_rdy, pld_rdy, hdr_vld, reqbypass, datareq, datareq16, be, credit_err = 0;
//   data = 0, parity = 8'hFF; oq_cnt = OQ_CREDITS, bq_cnt = BQ_CREDITS; beat counter 0.
//  All niu_sii_* outputs registered. Reset mid-transfer aborts; partial payload discarded.
//  FSM: IDLE, LOAD, WAIT, HDR, PLD.
//   IDLE: req_rdy=1. On accept capture hdr/be/write/bypass; write -> LOAD, read -> WAIT.
//   LOAD: pld_rdy=1; store beats into 4x128 buffer at cnt; after 4th beat -> WAIT.
//   WAIT: if target credit > 0 -> HDR (issue next cycle); else hold indefinitely.
//   HDR: one cycle hdr_vld=1, data=hdr, reqbypass/datareq from request; target credit -1.
//    write -> PLD, read -> IDLE.
//   PLD: 4 consecutive cycles, beat 0..3 in order, be=req_be, hdr_vld=0; then -> IDLE.
//  Latency: read accept at cycle t -> hdr_vld at t+2 with credit. Write: hdr 2 cycles after 4th beat.
//  Throughput: read every 3 cycles; no pipelining of next request during HDR/PLD.
//  Credits: 5-bit counters; decrement on HDR, increment on dq pulse; same cycle -> unchanged.
//   dq pulse with counter already at initial value: counter unchanged, credit_err set until reset.
//   oqdq and bqdq in the same cycle both honoured.
//  datareq=1 only on write header cycle; datareq16 never asserted.
//  Parity computed on driven data every cycle, including idle zeros.
// TESTING
//  Read, ordered, credit full: req_hdr=128'hA5.. -> hdr_vld 1 cycle, datareq=0, reqbypass=0, oq_cnt 16->15.
//  Write, bypass, beats D0..D3, be=16'hFFFF -> hdr with datareq=1, reqbypass=1, then D0..D3 on 4
//   consecutive cycles with be=FFFF, parity matches per lane; bq_cnt 4->3.
//  Credit exhaustion: 4 bypass reads, no bqdq -> 5th waits in WAIT; one bqdq pulse -> issues 2 cycles later.
//  Simultaneous HDR and oqdq with oq_cnt=5 -> oq_cnt stays 5; oqdq at oq_cnt=16 -> credit_err=1, stays 1.
//  rst_l low after 2 payload beats -> all outputs reset values asynchronously; next write needs 4 fresh beats.

Source files
------------

// File: rtl/niu_sii_req_packetizer.sv
// NIU->SII DMA request issue stage.
// Accepts one DMA read or write request at a time. A write's four payload beats
// are buffered in full before its header issues, so the beats go out
// back-to-back. Ordered and bypass queue credits are tracked separately and
// are returned by SII dequeue pulses.
module niu_sii_req_packetizer #(
  parameter int OQ_CREDITS = 16,
  parameter int BQ_CREDITS = 4
) (
  input  logic         iol2clk,
  input  logic         rst_l,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic         req_write,
  input  logic         req_bypass,
  input  logic [127:0] req_hdr,
  input  logic [15:0]  req_be,
  input  logic         pld_vld,
  output logic         pld_rdy,
  input  logic [127:0] pld_data,
  output logic         niu_sii_hdr_vld,
  output logic         niu_sii_reqbypass,
  output logic         niu_sii_datareq,
  output logic         niu_sii_datareq16,
  output logic [127:0] niu_sii_data,
  output logic [7:0]   niu_sii_parity,
  output logic [15:0]  niu_sii_be,
  input  logic         sii_niu_oqdq,
  input  logic         sii_niu_bqdq,
  output logic         credit_err
);

  localparam logic [4:0] OQ_INIT = 5'(OQ_CREDITS);
  localparam logic [4:0] BQ_INIT = 5'(BQ_CREDITS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    HDR  = 3'd3,
    PLD  = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic         req_rdy_q, req_rdy_d;
  logic         pld_rdy_q, pld_rdy_d;
  logic [127:0] hdr_q, hdr_d;
  logic [15:0]  be_q, be_d;
  logic         write_q, write_d;
  logic         bypass_q, bypass_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] pld_buf_q [4];
  logic [127:0] pld_buf_d [4];

  logic         hdr_vld_q, hdr_vld_d;
  logic         reqbypass_q, reqbypass_d;
  logic         datareq_q, datareq_d;
  logic [127:0] data_q, data_d;
  logic [7:0]   parity_q, parity_d;
  logic [15:0]  sii_be_q, sii_be_d;

  logic [4:0]   oq_cnt_q, oq_cnt_d;
  logic [4:0]   bq_cnt_q, bq_cnt_d;
  logic         credit_err_q, credit_err_d;

  logic         oq_dec;
  logic         bq_dec;
  logic         credit_avail;

  // The header cycle consumes one credit from the queue the request targets.
  assign oq_dec       = (state_q == HDR) && !bypass_q;
  assign bq_dec       = (state_q == HDR) &&  bypass_q;
  assign credit_avail = bypass_q ? (bq_cnt_q != 5'd0) : (oq_cnt_q != 5'd0);

  // Request FSM: next state, captured request fields, and next values of the registered bus outputs.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    be_d        = be_q;
    write_d     = write_q;
    bypass_d    = bypass_q;
    cnt_d       = cnt_q;
    pld_buf_d   = pld_buf_q;
    hdr_vld_d   = 1'b0;
    reqbypass_d = 1'b0;
    datareq_d   = 1'b0;
    data_d      = '0;
    sii_be_d    = '0;

    case (state_q)
      IDLE: begin
        if (req_vld && req_rdy_q) begin
          hdr_d    = req_hdr;
          be_d     = req_be;
          write_d  = req_write;
          bypass_d = req_bypass;
          cnt_d    = 2'd0;
          state_d  = req_write ? LOAD : WAIT;
        end
      end
      LOAD: begin
        if (pld_vld && pld_rdy_q) begin
          pld_buf_d[cnt_q] = pld_data;
          cnt_d            = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (credit_avail) begin
          state_d     = HDR;
          hdr_vld_d   = 1'b1;
          reqbypass_d = bypass_q;
          datareq_d   = write_q;
          data_d      = hdr_q;
        end
      end
      HDR: begin
        if (write_q) begin
          state_d  = PLD;
          data_d   = pld_buf_q[0];
          sii_be_d = be_q;
          cnt_d    = 2'd1;
        end else begin
          state_d = IDLE;
        end
      end
      PLD: begin
        // cnt wraps to 0 once beat 3 has been loaded into the output register.
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          data_d   = pld_buf_q[cnt_q];
          sii_be_d = be_q;
          cnt_d    = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_rdy_d = (state_d == IDLE);
    pld_rdy_d = (state_d == LOAD);
  end

  // Odd parity per 16-bit lane of whatever data is about to be driven, zeros included.
  always_comb begin
    parity_d = '1;
    for (int i = 0; i < 8; i++) begin
      parity_d[i] = ~^data_d[16*i +: 16];
    end
  end

  // Credit counters: a dequeue pulse and a header in the same cycle cancel; a return beyond the initial count is flagged.
  always_comb begin
    oq_cnt_d     = oq_cnt_q;
    bq_cnt_d     = bq_cnt_q;
    credit_err_d = credit_err_q;

    if (sii_niu_oqdq && !oq_dec) begin
      if (oq_cnt_q == OQ_INIT) begin
        credit_err_d = 1'b1;
      end else begin
        oq_cnt_d = oq_cnt_q + 5'd1;
      end
    end else if (!sii_niu_oqdq && oq_dec) begin
      oq_cnt_d = oq_cnt_q - 5'd1;
    end

    if (sii_niu_bqdq && !bq_dec) begin
      if (bq_cnt_q == BQ_INIT) begin
        credit_err_d = 1'b1;
      end else begin
        bq_cnt_d = bq_cnt_q + 5'd1;
      end
    end else if (!sii_niu_bqdq && bq_dec) begin
      bq_cnt_d = bq_cnt_q - 5'd1;
    end
  end

  // State, request fields, credits and bus outputs; reset aborts any transfer in flight.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      req_rdy_q    <= 1'b0;
      pld_rdy_q    <= 1'b0;
      hdr_q        <= '0;
      be_q         <= '0;
      write_q      <= 1'b0;
      bypass_q     <= 1'b0;
      cnt_q        <= 2'd0;
      hdr_vld_q    <= 1'b0;
      reqbypass_q  <= 1'b0;
      datareq_q    <= 1'b0;
      data_q       <= '0;
      parity_q     <= 8'hFF;
      sii_be_q     <= '0;
      oq_cnt_q     <= OQ_INIT;
      bq_cnt_q     <= BQ_INIT;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_rdy_q    <= req_rdy_d;
      pld_rdy_q    <= pld_rdy_d;
      hdr_q        <= hdr_d;
      be_q         <= be_d;
      write_q      <= write_d;
      bypass_q     <= bypass_d;
      cnt_q        <= cnt_d;
      hdr_vld_q    <= hdr_vld_d;
      reqbypass_q  <= reqbypass_d;
      datareq_q    <= datareq_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      sii_be_q     <= sii_be_d;
      oq_cnt_q     <= oq_cnt_d;
      bq_cnt_q     <= bq_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

  // Payload buffer needs no reset: it is always rewritten before being read.
  always_ff @(posedge iol2clk) begin
    pld_buf_q <= pld_buf_d;
  end

  assign req_rdy           = req_rdy_q;
  assign pld_rdy           = pld_rdy_q;
  assign niu_sii_hdr_vld   = hdr_vld_q;
  assign niu_sii_reqbypass = reqbypass_q;
  assign niu_sii_datareq   = datareq_q;
  assign niu_sii_datareq16 = 1'b0;
  assign niu_sii_data      = data_q;
  assign niu_sii_parity    = parity_q;
  assign niu_sii_be        = sii_be_q;
  assign credit_err        = credit_err_q;

endmodule

// File: tb/tb_niu_sii_req_packetizer.sv
// Self-checking bench for niu_sii_req_packetizer.
module tb_niu_sii_req_packetizer;

  localparam int OQ_INIT = 16;
  localparam int BQ_INIT = 4;

  logic         iol2clk = 1'b0;
  logic         rst_l = 1'b1;
  logic         req_vld = 1'b0;
  logic         req_rdy;
  logic         req_write = 1'b0;
  logic         req_bypass = 1'b0;
  logic [127:0] req_hdr = '0;
  logic [15:0]  req_be = '0;
  logic         pld_vld = 1'b0;
  logic         pld_rdy;
  logic [127:0] pld_data = '0;
  logic         niu_sii_hdr_vld;
  logic         niu_sii_reqbypass;
  logic         niu_sii_datareq;
  logic         niu_sii_datareq16;
  logic [127:0] niu_sii_data;
  logic [7:0]   niu_sii_parity;
  logic [15:0]  niu_sii_be;
  logic         sii_niu_oqdq = 1'b0;
  logic         sii_niu_bqdq = 1'b0;
  logic         credit_err;

  typedef struct packed {
    logic [31:0]  cyc;
    logic         isHdr;
    logic         bypass;
    logic         datareq;
    logic [15:0]  be;
    logic [127:0] data;
  } ev_t;

  ev_t expQ[$];
  ev_t obsQ[$];
  int  nChecks = 0;
  int  nFails  = 0;
  int  cycle   = 0;
  int  oqModel = OQ_INIT;
  int  bqModel = BQ_INIT;

  niu_sii_req_packetizer #(.OQ_CREDITS(OQ_INIT), .BQ_CREDITS(BQ_INIT)) dut (
    .iol2clk(iol2clk), .rst_l(rst_l),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_write(req_write), .req_bypass(req_bypass),
    .req_hdr(req_hdr), .req_be(req_be),
    .pld_vld(pld_vld), .pld_rdy(pld_rdy), .pld_data(pld_data),
    .niu_sii_hdr_vld(niu_sii_hdr_vld), .niu_sii_reqbypass(niu_sii_reqbypass),
    .niu_sii_datareq(niu_sii_datareq), .niu_sii_datareq16(niu_sii_datareq16),
    .niu_sii_data(niu_sii_data), .niu_sii_parity(niu_sii_parity), .niu_sii_be(niu_sii_be),
    .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq), .credit_err(credit_err)
  );

  always #5 iol2clk = ~iol2clk;

  always @(posedge iol2clk) cycle++;

  function automatic logic [7:0] parityOf(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] lane;
      lane = d[16*i +: 16];
      p[i] = ($countones(lane) % 2) == 0;
    end
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Record every header/payload cycle and check the always-true bus rules.
  always @(negedge iol2clk) begin
    if (rst_l) begin
      checkOutput("parity", 128'(niu_sii_parity), 128'(parityOf(niu_sii_data)));
      checkOutput("datareq16", 128'(niu_sii_datareq16), 128'(1'b0));
      if (niu_sii_hdr_vld) begin
        obsQ.push_back('{cyc: 32'(cycle), isHdr: 1'b1, bypass: niu_sii_reqbypass,
                         datareq: niu_sii_datareq, be: niu_sii_be, data: niu_sii_data});
      end else if (niu_sii_be != 16'h0) begin
        obsQ.push_back('{cyc: 32'(cycle), isHdr: 1'b0, bypass: 1'b0,
                         datareq: 1'b0, be: niu_sii_be, data: niu_sii_data});
      end else begin
        checkOutput("idle_data", niu_sii_data, 128'h0);
      end
    end
  end

  task automatic pushExpected(input logic wr, input logic byp, input logic [127:0] hdr, input logic [15:0] be,
                              input logic [127:0] d0, input logic [127:0] d1, input logic [127:0] d2,
                              input logic [127:0] d3, input int hdrCyc);
    logic [127:0] beats [4];
    beats = '{d0, d1, d2, d3};
    expQ.push_back('{cyc: 32'(hdrCyc), isHdr: 1'b1, bypass: byp, datareq: wr, be: 16'h0, data: hdr});
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        expQ.push_back('{cyc: 32'(hdrCyc + 1 + i), isHdr: 1'b0, bypass: 1'b0, datareq: 1'b0,
                         be: be, data: beats[i]});
      end
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic byp, input logic [127:0] hdr, input logic [15:0] be,
                               input logic [127:0] d0, input logic [127:0] d1, input logic [127:0] d2,
                               input logic [127:0] d3, input logic expectIssue, input int maxGap,
                               output int accCyc, output int lastCyc);
    logic [127:0] beats [4];
    int guard;
    int gap;
    beats = '{d0, d1, d2, d3};
    req_vld = 1'b1; req_write = wr; req_bypass = byp; req_hdr = hdr; req_be = be;
    guard = 0;
    while (!req_rdy && guard < 200) begin @(posedge iol2clk); #1; guard++; end
    checkOutput("req_handshake_timeout", 128'(guard < 200), 128'(1'b1));
    accCyc  = cycle;
    lastCyc = cycle;
    @(posedge iol2clk); #1;
    req_vld = 1'b0;
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        repeat (gap) begin @(posedge iol2clk); #1; end
        pld_vld = 1'b1; pld_data = beats[i];
        guard = 0;
        while (!pld_rdy && guard < 200) begin @(posedge iol2clk); #1; guard++; end
        checkOutput("pld_handshake_timeout", 128'(guard < 200), 128'(1'b1));
        lastCyc = cycle;
        @(posedge iol2clk); #1;
        pld_vld = 1'b0;
      end
    end
    if (expectIssue) pushExpected(wr, byp, hdr, be, d0, d1, d2, d3, (wr ? lastCyc : accCyc) + 2);
  endtask

  task automatic pulseDq(input logic oq, input logic bq);
    sii_niu_oqdq = oq; sii_niu_bqdq = bq;
    @(posedge iol2clk); #1;
    sii_niu_oqdq = 1'b0; sii_niu_bqdq = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    @(posedge iol2clk); #1;
    while (!req_rdy && guard < 200) begin @(posedge iol2clk); #1; guard++; end
    checkOutput("idle_timeout", 128'(guard < 200), 128'(1'b1));
  endtask

  task automatic compareEvents(input string phase);
    ev_t o;
    checkOutput({phase, "_event_count"}, 128'(obsQ.size()), 128'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      o = (i < obsQ.size()) ? obsQ[i] : '1;
      checkOutput($sformatf("%s_cycle%0d", phase, i), 128'(o.cyc), 128'(expQ[i].cyc));
      checkOutput($sformatf("%s_ctrl%0d", phase, i), 128'({o.isHdr, o.bypass, o.datareq, o.be}),
                  128'({expQ[i].isHdr, expQ[i].bypass, expQ[i].datareq, expQ[i].be}));
      checkOutput($sformatf("%s_data%0d", phase, i), o.data, expQ[i].data);
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic resetDut();
    rst_l = 1'b0;
    repeat (2) @(posedge iol2clk);
    #1 rst_l = 1'b1;
    oqModel = OQ_INIT; bqModel = BQ_INIT;
    expQ.delete(); obsQ.delete();
    @(posedge iol2clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc, acc2, last, p;
    logic wr, byp, oqR, bqR;
    logic [127:0] hdr, r0, r1, r2, r3;
    logic [15:0] be;

    // Reset values, checked while reset is held across clock edges.
    #1 rst_l = 1'b0;
    #2;
    checkOutput("rst_req_rdy", 128'(req_rdy), 128'(1'b0));
    checkOutput("rst_pld_rdy", 128'(pld_rdy), 128'(1'b0));
    checkOutput("rst_hdr_vld", 128'(niu_sii_hdr_vld), 128'(1'b0));
    checkOutput("rst_ctrl", 128'({niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16}), 128'(3'b000));
    checkOutput("rst_data", niu_sii_data, 128'h0);
    checkOutput("rst_parity", 128'(niu_sii_parity), 128'(8'hFF));
    checkOutput("rst_be", 128'(niu_sii_be), 128'(16'h0));
    checkOutput("rst_credit_err", 128'(credit_err), 128'(1'b0));
    checkOutput("rst_oq_cnt", 128'(dut.oq_cnt_q), 128'(OQ_INIT));
    checkOutput("rst_bq_cnt", 128'(dut.bq_cnt_q), 128'(BQ_INIT));
    repeat (3) @(posedge iol2clk);
    #1 rst_l = 1'b1;
    @(posedge iol2clk); #1;

    // Ordered read with full credit, then back-to-back reads to check 3-cycle throughput.
    hdr = {16{8'hA5}};
    applyStimulus(1'b0, 1'b0, hdr, 16'h0, '0, '0, '0, '0, 1'b1, 0, acc, last);
    oqModel--;
    waitIdle();
    compareEvents("rd_ord");
    checkOutput("rd_ord_oq_cnt", 128'(dut.oq_cnt_q), 128'(15));
    applyStimulus(1'b0, 1'b0, {4{32'h1111_2222}}, 16'h0, '0, '0, '0, '0, 1'b1, 0, acc, last);
    applyStimulus(1'b0, 1'b0, {4{32'h3333_4444}}, 16'h0, '0, '0, '0, '0, 1'b1, 0, acc2, last);
    oqModel -= 2;
    checkOutput("rd_throughput", 128'(acc2 - acc), 128'(3));
    waitIdle();
    compareEvents("rd_b2b");

    // Bypass write with four distinct beats and all byte enables.
    applyStimulus(1'b1, 1'b1, {4{32'hBEEF_0001}}, 16'hFFFF, {16{8'hD0}}, {16{8'hD1}}, {16{8'hD2}},
                  {16{8'hD3}}, 1'b1, 0, acc, last);
    bqModel--;
    waitIdle();
    compareEvents("wr_byp");
    checkOutput("wr_byp_bq_cnt", 128'(dut.bq_cnt_q), 128'(3));

    // Randomized mix of reads/writes with random credit returns and payload gaps.
    for (int n = 0; n < 40; n++) begin
      wr  = 1'($urandom_range(1, 0));
      byp = 1'($urandom_range(1, 0));
      hdr = {$urandom, $urandom, $urandom, $urandom};
      be  = 16'($urandom) | 16'h0001;
      r0  = {$urandom, $urandom, $urandom, $urandom};
      r1  = {$urandom, $urandom, $urandom, $urandom};
      r2  = {$urandom, $urandom, $urandom, $urandom};
      r3  = {$urandom, $urandom, $urandom, $urandom};
      oqR = (oqModel < OQ_INIT) && ($urandom_range(1, 0) == 1);
      bqR = (bqModel < BQ_INIT) && ($urandom_range(1, 0) == 1);
      if (!byp && oqModel == 0) oqR = 1'b1;
      if (byp && bqModel == 0) bqR = 1'b1;
      if (oqR || bqR) begin
        pulseDq(oqR, bqR);
        oqModel += int'(oqR);
        bqModel += int'(bqR);
      end
      applyStimulus(wr, byp, hdr, be, r0, r1, r2, r3, 1'b1, 2, acc, last);
      if (byp) bqModel--; else oqModel--;
      waitIdle();
    end
    compareEvents("random");
    checkOutput("random_oq_cnt", 128'(dut.oq_cnt_q), 128'(oqModel));
    checkOutput("random_bq_cnt", 128'(dut.bq_cnt_q), 128'(bqModel));
    checkOutput("random_credit_err", 128'(credit_err), 128'(1'b0));

    // Bypass credit exhaustion: fifth bypass read waits until a dequeue pulse.
    resetDut();
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b0, 1'b1, {4{32'hC0DE_0000 + n}}, 16'h0, '0, '0, '0, '0, 1'b1, 0, acc, last);
    end
    applyStimulus(1'b0, 1'b1, {4{32'hC0DE_00FF}}, 16'h0, '0, '0, '0, '0, 1'b0, 0, acc, last);
    repeat (8) begin @(posedge iol2clk); #1; end
    checkOutput("exhaust_stalled_req_rdy", 128'(req_rdy), 128'(1'b0));
    checkOutput("exhaust_bq_cnt", 128'(dut.bq_cnt_q), 128'(0));
    compareEvents("exhaust_pre");
    p = cycle;
    pulseDq(1'b0, 1'b1);
    pushExpected(1'b0, 1'b1, {4{32'hC0DE_00FF}}, 16'h0, '0, '0, '0, '0, p + 2);
    waitIdle();
    compareEvents("exhaust_post");
    checkOutput("exhaust_post_bq_cnt", 128'(dut.bq_cnt_q), 128'(0));

    // Header and ordered dequeue in the same cycle leave the count unchanged.
    resetDut();
    for (int n = 0; n < 11; n++) begin
      applyStimulus(1'b0, 1'b0, {4{32'h0D0D_0000 + n}}, 16'h0, '0, '0, '0, '0, 1'b1, 0, acc, last);
    end
    waitIdle();
    compareEvents("oq_fill");
    checkOutput("oq_cnt_5", 128'(dut.oq_cnt_q), 128'(5));
    applyStimulus(1'b0, 1'b0, {4{32'h5A5A_5A5A}}, 16'h0, '0, '0, '0, '0, 1'b1, 0, acc, last);
    @(posedge iol2clk); #1;
    pulseDq(1'b1, 1'b0);
    checkOutput("simul_hdr_dq_oq_cnt", 128'(dut.oq_cnt_q), 128'(5));
    waitIdle();
    compareEvents("simul");

    // Return credits to full, then one more: sticky error, count held.
    repeat (11) pulseDq(1'b1, 1'b0);
    checkOutput("oq_full_cnt", 128'(dut.oq_cnt_q), 128'(OQ_INIT));
    checkOutput("oq_full_no_err", 128'(credit_err), 128'(1'b0));
    pulseDq(1'b1, 1'b0);
    checkOutput("oq_over_err", 128'(credit_err), 128'(1'b1));
    checkOutput("oq_over_cnt", 128'(dut.oq_cnt_q), 128'(OQ_INIT));
    repeat (3) begin @(posedge iol2clk); #1; end
    pulseDq(1'b0, 1'b1);
    checkOutput("err_sticky", 128'(credit_err), 128'(1'b1));
    checkOutput("bq_over_cnt", 128'(dut.bq_cnt_q), 128'(BQ_INIT));

    // Reset after two payload beats: outputs clear asynchronously, next write needs four fresh beats.
    req_vld = 1'b1; req_write = 1'b1; req_bypass = 1'b0; req_hdr = {4{32'hDEAD_0000}}; req_be = 16'h00FF;
    p = 0;
    while (!req_rdy && p < 200) begin @(posedge iol2clk); #1; p++; end
    @(posedge iol2clk); #1;
    req_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pld_vld = 1'b1; pld_data = {16{8'h70 + 8'(i)}};
      p = 0;
      while (!pld_rdy && p < 200) begin @(posedge iol2clk); #1; p++; end
      @(posedge iol2clk); #1;
    end
    pld_vld = 1'b0;
    checkOutput("mid_pld_rdy_before", 128'(pld_rdy), 128'(1'b1));
    #2 rst_l = 1'b0;
    #1;
    checkOutput("mid_rst_pld_rdy", 128'(pld_rdy), 128'(1'b0));
    checkOutput("mid_rst_req_rdy", 128'(req_rdy), 128'(1'b0));
    checkOutput("mid_rst_credit_err", 128'(credit_err), 128'(1'b0));
    checkOutput("mid_rst_hdr_vld", 128'(niu_sii_hdr_vld), 128'(1'b0));
    checkOutput("mid_rst_parity", 128'(niu_sii_parity), 128'(8'hFF));
    checkOutput("mid_rst_oq_cnt", 128'(dut.oq_cnt_q), 128'(OQ_INIT));
    @(posedge iol2clk);
    #1 rst_l = 1'b1;
    oqModel = OQ_INIT; bqModel = BQ_INIT;
    expQ.delete(); obsQ.delete();
    @(posedge iol2clk); #1;
    applyStimulus(1'b1, 1'b0, {4{32'hF00D_0001}}, 16'h0F0F, {16{8'hE0}}, {16{8'hE1}}, {16{8'hE2}},
                  {16{8'hE3}}, 1'b1, 1, acc, last);
    waitIdle();
    compareEvents("post_rst_wr");
    checkOutput("post_rst_oq_cnt", 128'(dut.oq_cnt_q), 128'(OQ_INIT - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
